j1b_uart: RTL and testbench
===========================

Name: j1b_uart

Overview:
- Byte-serial UART serving the j1b I/O space at address bit 12: consumes the CPU's uart0_wr/uart_w write strobe and uart0_rd pop strobe; produces uart0_valid/uart0_data.
- Serialises TX bytes onto txd and deserialises rxd into an RX FIFO.
- Frame format is 8N1, LSB first. Both directions are buffered, because the CPU status word hard-wires "TX ready" to 1 and never polls before writing.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per bit (12 MHz / 115200); must be >= 4.
- RX_DEPTH, 16, RX FIFO entries; power of two, >= 2.
- TX_DEPTH, 16, TX FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high. Named without the q suffix because q denotes active-low in this codebase.
- uart0_wr  in  1  one-cycle strobe: push uart_w into the TX FIFO.
- uart_w  in  8  TX byte, sampled when uart0_wr=1.
- uart0_rd  in  1  one-cycle strobe: pop the RX FIFO head.
- uart0_valid  out  1  RX FIFO non-empty.
- uart0_data  out  8  RX FIFO head; 8'h00 when empty.
- txd  out  1  serial out, idle high.
- rxd  in  1  serial in, asynchronous to clk.
- tx_ready  out  1  TX FIFO not full.
- tx_busy  out  1  TX FSM not IDLE, or TX FIFO non-empty.
- rx_overrun  out  1  one-cycle pulse: a received byte was dropped because the RX FIFO was full.
- tx_overrun  out  1  one-cycle pulse: a write was dropped because the TX FIFO was full and not popping.
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled 0.

Behaviour:
- Reset values (asynchronous, all registers):
  - txd=1; both FIFOs empty, so uart0_valid=0, uart0_data=0, tx_ready=1, tx_busy=0.
  - All pulses 0; both FSMs IDLE.
  - rxd synchroniser flops =1.
- Reset mid-frame aborts immediately: txd returns high in the same cycle; partial RX byte is discarded.
- FIFO rules:
  - Push and pop in the same cycle are both honoured and count is unchanged, including when the FIFO is full.
  - Pop when empty is ignored; push when full (with no pop) is dropped and raises the matching overrun pulse.
  - Pointers wrap modulo depth; occupancy counter is log2(DEPTH)+1 bits wide.
  - uart0_valid and uart0_data reflect the FIFO state after the clock edge. The pop takes effect at the edge where uart0_rd=1, and the CPU samples uart0_data during that same cycle.
- TX FSM (IDLE, START, DATA, STOP), with bit counter 0..7 and baud counter 0..CLKS_PER_BIT-1:
  - IDLE with TX FIFO non-empty: pop into the shift register, go to START, drive txd=0.
  - Each state holds its bit for exactly CLKS_PER_BIT cycles.
  - DATA shifts LSB first through 8 bits, then STOP drives txd=1.
  - At the end of STOP: if the FIFO is non-empty, go straight to START (no idle gap); otherwise go to IDLE.
  - Latency: uart0_wr high in cycle N with the FSM idle → txd low from cycle N+2. Frame length is 10*CLKS_PER_BIT cycles.
- RX FSM (IDLE, START, DATA, STOP) operates on rxd after a 2-flop synchroniser:
  - IDLE: on a synchronised 1→0 edge, go to START.
  - START: at CLKS_PER_BIT/2 cycles, re-sample. If the line is 1 (glitch), return to IDLE with no output.
  - DATA: sample 8 bits at CLKS_PER_BIT intervals from the start-bit midpoint, LSB first.
  - STOP: sample at the stop-bit midpoint.
    - If 1: push the byte, and uart0_valid rises the next cycle.
    - If 0: discard the byte, pulse rx_frame_err, and wait in STOP until rxd=1 before returning to IDLE (no false start on a break).
  - After a good stop sample, go to IDLE immediately so that back-to-back frames are caught.
- Simultaneous events:
  - RX push and CPU pop in the same cycle are both performed.
  - uart0_wr during a TX FIFO pop is accepted even when the FIFO is full.

Decomposition:
- Package uart_pkg holds:
  - frame constants DATA_BITS=8 and STOP_BITS=1;
  - typedef enum uart_state_t {IDLE, START, DATA, STOP}, shared by the TX and RX FSMs.
- Sub-module uart_fifo (params WIDTH, DEPTH; ports push, pop, din, dout, empty, full, overrun), instantiated once for RX and once for TX.
- The TX and RX FSMs stay inline in j1b_uart.

Test Plan (CLKS_PER_BIT=4, depths 4):
- uart0_wr with uart_w=8'h55 at cycle 10 → txd low at cycle 12; bit levels 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; idle high from cycle 52; tx_busy falls the same cycle.
- Loopback rxd=txd, write 8'hA5 → uart0_valid=1, uart0_data=8'hA5. uart0_rd for one cycle → valid=0 and data=8'h00 the next cycle.
- Drive 5 frames 8'h01..8'h05 into rxd with no reads → rx_overrun pulses exactly once, on byte 5. Four reads return 01, 02, 03, 04, then valid=0.
- Six back-to-back writes with TX busy → tx_overrun pulses once; txd emits bytes 1-5 with no idle gaps.
- rxd low for 1 cycle → no push, no error. Frame 8'h3C with stop bit 0 → rx_frame_err pulse, valid stays 0. The next good frame 8'h7E is received correctly.
- Assert reset mid-TX (bit 3) and mid-RX → txd=1 during reset, FIFOs empty. After release, a new write 8'hC3 transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared frame constants and the FSM state type used by both UART directions.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with simultaneous push/pop; reads back zero when empty and
// flags a dropped push with a one-cycle overrun pulse.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCount);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];
  assign overrun = overrun_q;

  always_comb begin
    do_pop    = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    do_push   = push && (!full || do_pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = push && !do_push;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) count_d = count_q + (AW + 1)'(1);
    if (!do_push && do_pop) count_d = count_q - (AW + 1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      if (do_push) mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/j1b_uart.sv
// Buffered 8N1 UART for the j1b I/O space: TX FIFO feeding a serialiser on txd,
// and a synchronised rxd deserialiser feeding an RX FIFO read by the CPU.
module j1b_uart
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned RX_DEPTH     = 16,
  parameter int unsigned TX_DEPTH     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart0_wr,
  input  logic [7:0] uart_w,
  input  logic       uart0_rd,
  output logic       uart0_valid,
  output logic [7:0] uart0_data,
  output logic       txd,
  input  logic       rxd,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       rx_overrun,
  output logic       tx_overrun,
  output logic       rx_frame_err
);

  localparam int unsigned     BaudW    = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BaudW-1:0] BaudHalf = BaudW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       BitLast  = 3'(DATA_BITS - 1);
  localparam logic [2:0]       StopLast = 3'(STOP_BITS - 1);

  logic       tx_pop, tx_empty, tx_full;
  logic [7:0] tx_dout;
  logic       rx_push, rx_empty, rx_full_unused;

  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (uart0_wr),
    .pop     (tx_pop),
    .din     (uart_w),
    .dout    (tx_dout),
    .empty   (tx_empty),
    .full    (tx_full),
    .overrun (tx_overrun)
  );

  // ---------------- TX ----------------
  uart_state_t     tx_state_q, tx_state_d;
  logic [BaudW-1:0] tx_baud_q, tx_baud_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             txd_q, txd_d;

  assign txd      = txd_q;
  assign tx_ready = !tx_full;
  assign tx_busy  = (tx_state_q != StIdle) || !tx_empty;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      StIdle: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_dout;
          txd_d      = 1'b0;
          tx_baud_d  = '0;
          tx_state_d = StStart;
        end
      end
      StStart: begin
        if (tx_baud_q == BaudLast) begin
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_state_d = StData;
        end else begin
          tx_baud_d = tx_baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (tx_baud_q == BaudLast) begin
          tx_baud_d = '0;
          if (tx_bit_q == BitLast) begin
            tx_bit_d   = '0;
            txd_d      = 1'b1;
            tx_state_d = StStop;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_baud_d = tx_baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (tx_baud_q == BaudLast) begin
          tx_baud_d = '0;
          if (tx_bit_q != StopLast) begin
            tx_bit_d = tx_bit_q + 3'd1;
          end else if (!tx_empty) begin
            // Chain straight into the next start bit so queued bytes leave gap-free.
            tx_pop     = 1'b1;
            tx_shift_d = tx_dout;
            txd_d      = 1'b0;
            tx_state_d = StStart;
          end else begin
            tx_state_d = StIdle;
          end
        end else begin
          tx_baud_d = tx_baud_q + BaudW'(1);
        end
      end
      default: tx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= StIdle;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  // ---------------- RX ----------------
  logic             sync1_q, sync2_q, rx_prev_q;
  uart_state_t      rx_state_q, rx_state_d;
  logic [BaudW-1:0] rx_baud_q, rx_baud_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_brk_q, rx_brk_d;
  logic             ferr_q, ferr_d;

  assign rx_frame_err = ferr_q;
  assign uart0_valid  = !rx_empty;

  uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (rx_push),
    .pop     (uart0_rd),
    .din     (rx_shift_q),
    .dout    (uart0_data),
    .empty   (rx_empty),
    .full    (rx_full_unused),
    .overrun (rx_overrun)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_brk_d   = rx_brk_q;
    ferr_d     = 1'b0;
    rx_push    = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        if (rx_prev_q && !sync2_q) begin
          rx_baud_d  = '0;
          rx_state_d = StStart;
        end
      end
      StStart: begin
        if (rx_baud_q == BaudHalf) begin
          rx_baud_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = sync2_q ? StIdle : StData;
        end else begin
          rx_baud_d = rx_baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (rx_baud_q == BaudLast) begin
          rx_baud_d  = '0;
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == BitLast) begin
            rx_brk_d   = 1'b0;
            rx_state_d = StStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_baud_d = rx_baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (rx_brk_q) begin
          // Hold off until the line idles so a break is not seen as a new start.
          if (sync2_q) begin
            rx_brk_d   = 1'b0;
            rx_state_d = StIdle;
          end
        end else if (rx_baud_q == BaudLast) begin
          rx_baud_d = '0;
          if (sync2_q) begin
            rx_push    = 1'b1;
            rx_state_d = StIdle;
          end else begin
            ferr_d   = 1'b1;
            rx_brk_d = 1'b1;
          end
        end else begin
          rx_baud_d = rx_baud_q + BaudW'(1);
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_brk_q   <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync1_q    <= rxd;
      sync2_q    <= sync1_q;
      rx_prev_q  <= sync2_q;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_brk_q   <= rx_brk_d;
      ferr_q     <= ferr_d;
    end
  end

endmodule

// File: tb/tb_j1b_uart.sv
// Self-checking bench for j1b_uart: expected serial streams and RX FIFO contents
// come from a frame-level model (bit lists and a bounded byte queue).
module tb_j1b_uart;

  localparam int unsigned C = 4;
  localparam int unsigned D = 4;

  typedef logic bitq_t[$];
  typedef logic [7:0] byteq_t[$];

  logic       clk = 1'b0;
  logic       reset, uart0_wr, uart0_rd, rxd, txd;
  logic [7:0] uart_w, uart0_data;
  logic       uart0_valid, tx_ready, tx_busy, rx_overrun, tx_overrun, rx_frame_err;
  logic       loopback, rxd_drv, rec;

  int    vectors, miscompares;
  int    rx_ovr_n, tx_ovr_n, ferr_n;
  bitq_t txlog;

  assign rxd = loopback ? txd : rxd_drv;

  j1b_uart #(.CLKS_PER_BIT(C), .RX_DEPTH(D), .TX_DEPTH(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .uart0_wr     (uart0_wr),
    .uart_w       (uart_w),
    .uart0_rd     (uart0_rd),
    .uart0_valid  (uart0_valid),
    .uart0_data   (uart0_data),
    .txd          (txd),
    .rxd          (rxd),
    .tx_ready     (tx_ready),
    .tx_busy      (tx_busy),
    .rx_overrun   (rx_overrun),
    .tx_overrun   (tx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clk = ~clk;

  // Advance one cycle and sample on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (rx_overrun)   rx_ovr_n++;
    if (tx_overrun)   tx_ovr_n++;
    if (rx_frame_err) ferr_n++;
    if (rec) txlog.push_back(txd);
  endtask

  // Line level one cycle after the write, then each frame bit held C cycles, then idle.
  function automatic bitq_t make_stream(input byteq_t bytes);
    bitq_t q;
    q.push_back(1'b1);
    foreach (bytes[i]) begin
      for (int k = 0; k < 10; k++) begin
        logic lvl;
        lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : bytes[i][k-1];
        for (int r = 0; r < C; r++) q.push_back(lvl);
      end
    end
    for (int r = 0; r < 4; r++) q.push_back(1'b1);
    return q;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    for (int k = 0; k < 10; k++) begin
      rxd_drv = (k == 0) ? 1'b0 : (k == 9) ? stop_bit : b[k-1];
      repeat (C) tick();
    end
    rxd_drv = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; uart0_wr = 1'b0; uart0_rd = 1'b0; uart_w = '0;
    loopback = 1'b0; rxd_drv = 1'b1; rec = 1'b0;
    repeat (2) tick();
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL reset_txd: got %b want 1", txd); end
    vectors++; if (uart0_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", uart0_valid); end
    vectors++; if (uart0_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", uart0_data); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
    vectors++;
    if ({rx_overrun, tx_overrun, rx_frame_err} !== 3'b000) begin
      miscompares++; $display("FAIL reset_pulses: got %b want 000", {rx_overrun, tx_overrun, rx_frame_err});
    end
    reset = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_tx_basic();
    byteq_t bytes;
    bytes = '{8'h55, 8'($urandom_range(255, 0))};
    foreach (bytes[i]) begin
      byteq_t one;
      bitq_t  exp;
      one = '{bytes[i]};
      exp = make_stream(one);
      tx_ovr_n = 0;
      txlog.delete(); rec = 1'b1;
      uart_w = bytes[i]; uart0_wr = 1'b1;
      tick();
      uart0_wr = 1'b0;
      vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL tx_busy_queued: got %b want 1", tx_busy); end
      while (txlog.size() < exp.size()) begin
        tick();
        if (txlog.size() == 41) begin
          vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL tx_busy_stop: got %b want 1", tx_busy); end
        end
        if (txlog.size() == 42) begin
          vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL tx_busy_idle: got %b want 0", tx_busy); end
        end
      end
      rec = 1'b0;
      for (int k = 0; k < exp.size(); k++) begin
        vectors++;
        if (txlog[k] !== exp[k]) begin
          miscompares++; $display("FAIL tx_basic[%0d] byte %h: got %b want %b", k, bytes[i], txlog[k], exp[k]);
        end
      end
      vectors++; if (tx_ovr_n != 0) begin miscompares++; $display("FAIL tx_basic_overrun: got %0d want 0", tx_ovr_n); end
    end
  endtask

  task automatic test_loopback();
    byteq_t bytes;
    bytes = '{8'hA5, 8'($urandom_range(255, 0))};
    loopback = 1'b1; ferr_n = 0;
    foreach (bytes[i]) begin
      int n;
      uart_w = bytes[i]; uart0_wr = 1'b1;
      tick();
      uart0_wr = 1'b0;
      n = 0;
      while (!uart0_valid && n < 200) begin tick(); n++; end
      vectors++; if (uart0_valid !== 1'b1) begin miscompares++; $display("FAIL loop_valid: got %b want 1", uart0_valid); end
      vectors++; if (uart0_data !== bytes[i]) begin miscompares++; $display("FAIL loop_data: got %h want %h", uart0_data, bytes[i]); end
      uart0_rd = 1'b1;
      tick();
      uart0_rd = 1'b0;
      vectors++; if (uart0_valid !== 1'b0) begin miscompares++; $display("FAIL loop_pop_valid: got %b want 0", uart0_valid); end
      vectors++; if (uart0_data !== 8'h00) begin miscompares++; $display("FAIL loop_pop_data: got %h want 00", uart0_data); end
      repeat (10) tick();
    end
    vectors++; if (ferr_n != 0) begin miscompares++; $display("FAIL loop_frame_err: got %0d want 0", ferr_n); end
    loopback = 1'b0;
  endtask

  task automatic test_rx_overrun();
    byteq_t model;
    int     exp_ovr;
    exp_ovr = 0; rx_ovr_n = 0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      if (model.size() < D) model.push_back(8'(i)); else exp_ovr++;
      vectors++;
      if (rx_ovr_n != exp_ovr) begin
        miscompares++; $display("FAIL rx_overrun_after_%0d: got %0d want %0d", i, rx_ovr_n, exp_ovr);
      end
    end
    while (model.size() > 0) begin
      logic [7:0] e;
      e = model.pop_front();
      vectors++; if (uart0_valid !== 1'b1) begin miscompares++; $display("FAIL rx_read_valid: got %b want 1", uart0_valid); end
      vectors++; if (uart0_data !== e) begin miscompares++; $display("FAIL rx_read_data: got %h want %h", uart0_data, e); end
      uart0_rd = 1'b1;
      tick();
      uart0_rd = 1'b0;
    end
    vectors++; if (uart0_valid !== 1'b0) begin miscompares++; $display("FAIL rx_drained: got %b want 0", uart0_valid); end
  endtask

  task automatic test_back_to_back();
    byteq_t bytes, sent;
    bitq_t  exp;
    for (int i = 0; i < 6; i++) bytes.push_back(8'($urandom_range(255, 0)));
    for (int i = 0; i < 5; i++) sent.push_back(bytes[i]);
    exp = make_stream(sent);
    tx_ovr_n = 0;
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got %b want 0", tx_busy); end
    txlog.delete(); rec = 1'b1;
    for (int i = 0; i < 6; i++) begin
      uart_w = bytes[i]; uart0_wr = 1'b1;
      if (i == 5) begin
        vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_tx_ready: got %b want 0", tx_ready); end
      end
      tick();
    end
    uart0_wr = 1'b0;
    while (txlog.size() < exp.size()) tick();
    rec = 1'b0;
    for (int k = 0; k < exp.size(); k++) begin
      vectors++;
      if (txlog[k] !== exp[k]) begin
        miscompares++; $display("FAIL b2b_stream[%0d]: got %b want %b", k, txlog[k], exp[k]);
      end
    end
    vectors++; if (tx_ovr_n != 1) begin miscompares++; $display("FAIL b2b_overrun: got %0d want 1", tx_ovr_n); end
  endtask

  task automatic test_rx_errors();
    logic [7:0] r;
    ferr_n = 0;
    rxd_drv = 1'b0;
    tick();
    rxd_drv = 1'b1;
    repeat (12) tick();
    vectors++; if (uart0_valid !== 1'b0) begin miscompares++; $display("FAIL glitch_valid: got %b want 0", uart0_valid); end
    vectors++; if (ferr_n != 0) begin miscompares++; $display("FAIL glitch_ferr: got %0d want 0", ferr_n); end
    send_frame(8'h3C, 1'b0);
    vectors++; if (ferr_n != 1) begin miscompares++; $display("FAIL bad_stop_ferr: got %0d want 1", ferr_n); end
    vectors++; if (uart0_valid !== 1'b0) begin miscompares++; $display("FAIL bad_stop_valid: got %b want 0", uart0_valid); end
    r = 8'($urandom_range(255, 0));
    send_frame(8'h7E, 1'b1);
    send_frame(r, 1'b1);
    vectors++; if (uart0_data !== 8'h7E) begin miscompares++; $display("FAIL good_after_err: got %h want 7e", uart0_data); end
    uart0_rd = 1'b1; tick(); uart0_rd = 1'b0;
    vectors++; if (uart0_data !== r) begin miscompares++; $display("FAIL rand_after_err: got %h want %h", uart0_data, r); end
    uart0_rd = 1'b1; tick(); uart0_rd = 1'b0;
    vectors++; if (ferr_n != 1) begin miscompares++; $display("FAIL ferr_total: got %0d want 1", ferr_n); end
  endtask

  task automatic test_reset_mid();
    byteq_t bytes;
    bitq_t  exp;
    uart_w = 8'($urandom_range(255, 0)); uart0_wr = 1'b1;
    tick();
    uart0_wr = 1'b0;
    rxd_drv = 1'b0;
    repeat (19) tick();
    reset = 1'b1;
    #1;
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL midreset_txd: got %b want 1", txd); end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", tx_busy); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_ready: got %b want 1", tx_ready); end
    vectors++; if (uart0_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid: got %b want 0", uart0_valid); end
    repeat (3) tick();
    rxd_drv = 1'b1;
    reset = 1'b0;
    repeat (50) tick();
    vectors++; if (uart0_valid !== 1'b0) begin miscompares++; $display("FAIL postreset_valid: got %b want 0", uart0_valid); end
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL postreset_txd: got %b want 1", txd); end
    bytes = '{8'hC3};
    exp = make_stream(bytes);
    txlog.delete(); rec = 1'b1;
    uart_w = 8'hC3; uart0_wr = 1'b1;
    tick();
    uart0_wr = 1'b0;
    while (txlog.size() < exp.size()) tick();
    rec = 1'b0;
    for (int k = 0; k < exp.size(); k++) begin
      vectors++;
      if (txlog[k] !== exp[k]) begin
        miscompares++; $display("FAIL postreset_stream[%0d]: got %b want %b", k, txlog[k], exp[k]);
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rx_ovr_n = 0; tx_ovr_n = 0; ferr_n = 0;
    test_reset();
    test_tx_basic();
    test_loopback();
    test_rx_overrun();
    test_back_to_back();
    test_rx_errors();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
